// File: rtl/fire9_expand1_ofm_writer_if.sv
// Pixel-in / RAM-write-out bundle for the fire9 expand1 OFM writer.
// master = pixel producer and RAM side, slave = the writer itself.
interface fire9_expand1_ofm_writer_if #(
    parameter int WIDTH                = 16,
    parameter int DSP_NO_FIRE9_EXPAND1 = 368,
    parameter int WOUT_FIRE9_EXPAND1   = 8,
    parameter int BANKS                = 4
);
    localparam int CPB    = DSP_NO_FIRE9_EXPAND1 / BANKS;
    localparam int NPIX   = WOUT_FIRE9_EXPAND1 * WOUT_FIRE9_EXPAND1;
    localparam int ADDR_W = $clog2(CPB * NPIX);

    logic                   sample_i;
    logic [WIDTH-1:0]       ofm_i [DSP_NO_FIRE9_EXPAND1];
    logic [BANKS-1:0]       wr_en_o;
    logic [ADDR_W-1:0]      wr_addr_o;
    logic [WIDTH-1:0]       wr_data_o [BANKS];
    logic                   layer_done_o;
    logic                   next_layer_start_o;
    logic                   overrun_o;

    modport master (
        output sample_i, ofm_i,
        input  wr_en_o, wr_addr_o, wr_data_o, layer_done_o, next_layer_start_o, overrun_o
    );

    modport slave (
        input  sample_i, ofm_i,
        output wr_en_o, wr_addr_o, wr_data_o, layer_done_o, next_layer_start_o, overrun_o
    );
endinterface

// File: rtl/fire9_expand1_ofm_writer.sv
// Spreads one output pixel (all channels) over BANKS RAM lanes, CPB writes per pixel,
// channel-major addressing k*NPIX + pix; flags the end of the layer and dropped samples.
module fire9_expand1_ofm_writer #(
    parameter int WIDTH                = 16,
    parameter int DSP_NO_FIRE9_EXPAND1 = 368,
    parameter int WOUT_FIRE9_EXPAND1   = 8,
    parameter int BANKS                = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fire9_expand1_ofm_writer_if.slave  bus
);
    localparam int CPB    = DSP_NO_FIRE9_EXPAND1 / BANKS;
    localparam int NPIX   = WOUT_FIRE9_EXPAND1 * WOUT_FIRE9_EXPAND1;
    localparam int ADDR_W = $clog2(CPB * NPIX);
    localparam int K_W    = $clog2(CPB);
    localparam int PIX_W  = $clog2(NPIX + 1);
    localparam int IDX_W  = $clog2(DSP_NO_FIRE9_EXPAND1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [K_W-1:0]    k;
    logic [PIX_W-1:0]  pix;
    logic [WIDTH-1:0]  shadow [DSP_NO_FIRE9_EXPAND1];

    logic [BANKS-1:0]  wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q [BANKS];
    logic              layer_done_q;
    logic              next_layer_start_q;
    logic              overrun_q;

    logic              last_k;
    logic              accept_idle;
    logic              accept_b2b;
    logic              accept;
    logic [K_W-1:0]    k_nxt;
    logic [IDX_W-1:0]  rd_idx    [BANKS];
    logic [WIDTH-1:0]  bank_word [BANKS];

    function automatic logic [ADDR_W-1:0] addr_of(input logic [K_W-1:0] kk,
                                                  input logic [PIX_W-1:0] pp);
        return ADDR_W'(int'(kk) * NPIX + int'(pp));
    endfunction

    assign last_k      = (k == K_W'(CPB - 1));
    assign accept_idle = (state == S_IDLE) && bus.sample_i;
    // A new pixel may chain onto the final write of the current one, but never past the layer end.
    assign accept_b2b  = (state == S_WRITE) && last_k && bus.sample_i
                         && (pix < PIX_W'(NPIX - 1));
    assign accept      = accept_idle || accept_b2b;
    assign k_nxt       = last_k ? '0 : k + 1'b1;

    // The k=0 word of a freshly accepted pixel comes straight from the input,
    // since the shadow copy only lands on the same edge.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        localparam int BASE = b * CPB;
        assign rd_idx[b]    = IDX_W'(BASE) + IDX_W'(k_nxt);
        assign bank_word[b] = accept ? bus.ofm_i[BASE] : shadow[rd_idx[b]];
    end

    always_ff @(posedge clk) begin
        if (accept) shadow <= bus.ofm_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            k                  <= '0;
            pix                <= '0;
            wr_en_q            <= '0;
            wr_addr_q          <= '0;
            for (int b = 0; b < BANKS; b++) wr_data_q[b] <= '0;
            layer_done_q       <= 1'b0;
            next_layer_start_q <= 1'b0;
            overrun_q          <= 1'b0;
        end else begin
            next_layer_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    wr_en_q <= '0;
                    if (accept_idle) begin
                        state     <= S_WRITE;
                        k         <= '0;
                        wr_en_q   <= '1;
                        wr_addr_q <= addr_of('0, pix);
                        wr_data_q <= bank_word;
                    end
                end
                S_WRITE: begin
                    if (!last_k) begin
                        k         <= k_nxt;
                        wr_en_q   <= '1;
                        wr_addr_q <= addr_of(k_nxt, pix);
                        wr_data_q <= bank_word;
                        if (bus.sample_i) overrun_q <= 1'b1;
                    end else begin
                        pix <= pix + 1'b1;
                        k   <= '0;
                        if (accept_b2b) begin
                            wr_en_q   <= '1;
                            wr_addr_q <= addr_of('0, pix + 1'b1);
                            wr_data_q <= bank_word;
                        end else begin
                            wr_en_q <= '0;
                            if (pix == PIX_W'(NPIX - 1)) begin
                                state              <= S_DONE;
                                layer_done_q       <= 1'b1;
                                next_layer_start_q <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    wr_en_q <= '0;
                end
                default: begin
                    state   <= S_IDLE;
                    wr_en_q <= '0;
                end
            endcase
        end
    end

    assign bus.wr_en_o            = wr_en_q;
    assign bus.wr_addr_o          = wr_addr_q;
    assign bus.wr_data_o          = wr_data_q;
    assign bus.layer_done_o       = layer_done_q;
    assign bus.next_layer_start_o = next_layer_start_q;
    assign bus.overrun_o          = overrun_q;
endmodule

// File: tb/tb_fire9_expand1_ofm_writer.sv
// Bench for fire9_expand1_ofm_writer: queue-of-expected-writes model plus directed literals.
module tb_fire9_expand1_ofm_writer;
    localparam int WIDTH  = 16;
    localparam int DSP    = 368;
    localparam int WOUT   = 8;
    localparam int BANKS  = 4;
    localparam int CPB    = DSP / BANKS;
    localparam int NPIX   = WOUT * WOUT;
    localparam int ADDR_W = $clog2(CPB * NPIX);

    typedef struct packed {
        logic [ADDR_W-1:0]            addr;
        logic [BANKS-1:0][WIDTH-1:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fire9_expand1_ofm_writer_if #(
        .WIDTH(WIDTH), .DSP_NO_FIRE9_EXPAND1(DSP),
        .WOUT_FIRE9_EXPAND1(WOUT), .BANKS(BANKS)
    ) bus ();

    fire9_expand1_ofm_writer #(
        .WIDTH(WIDTH), .DSP_NO_FIRE9_EXPAND1(DSP),
        .WOUT_FIRE9_EXPAND1(WOUT), .BANKS(BANKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int wr_cnt = 0;
    int nls_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 25) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: an accepted pixel becomes CPB queued writes issued one per cycle from the next cycle.
    wr_t                         q[$];
    bit                          m_wr = 0, m_done = 0, m_nls = 0, m_ovr = 0;
    int                          m_taken = 0;
    logic [ADDR_W-1:0]           m_addr = '0;
    logic [BANKS-1:0][WIDTH-1:0] m_data = '0;

    task automatic model_step();
        wr_t w;
        if (rst) begin
            q.delete();
            m_wr = 0; m_done = 0; m_nls = 0; m_ovr = 0; m_taken = 0;
            m_addr = '0; m_data = '0;
        end else begin
            m_nls = 0;
            if (bus.sample_i && !m_done) begin
                if (q.size() == 0 && m_taken < NPIX) begin
                    for (int kk = 0; kk < CPB; kk++) begin
                        w.addr = ADDR_W'(kk * NPIX + m_taken);
                        for (int b = 0; b < BANKS; b++) w.d[b] = bus.ofm_i[b * CPB + kk];
                        q.push_back(w);
                    end
                    m_taken++;
                end else if (q.size() != 0) begin
                    m_ovr = 1;
                end
            end
            if (q.size() != 0) begin
                w = q.pop_front();
                m_wr = 1; m_addr = w.addr; m_data = w.d;
            end else begin
                m_wr = 0;
            end
            if (!m_done && m_taken == NPIX && !m_wr) begin
                m_done = 1; m_nls = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("wr_en", 64'(bus.wr_en_o), m_wr ? 64'(4'hF) : 64'd0);
            chk("wr_addr", 64'(bus.wr_addr_o), 64'(m_addr));
            for (int b = 0; b < BANKS; b++) chk("wr_data", 64'(bus.wr_data_o[b]), 64'(m_data[b]));
            chk("layer_done", 64'(bus.layer_done_o), 64'(m_done));
            chk("next_layer_start", 64'(bus.next_layer_start_o), 64'(m_nls));
            chk("overrun", 64'(bus.overrun_o), 64'(m_ovr));
            if (bus.wr_en_o == 4'hF) wr_cnt++;
            if (bus.next_layer_start_o) nls_cnt++;
        end
    end

    task automatic set_ofm_ramp(input int off);
        for (int c = 0; c < DSP; c++) bus.ofm_i[c] = WIDTH'(c + off);
    endtask

    task automatic set_ofm_rand();
        for (int c = 0; c < DSP; c++) bus.ofm_i[c] = WIDTH'($urandom);
    endtask

    // Leaves the bench at the negedge of the first write cycle.
    task automatic pulse();
        bus.sample_i = 1'b1;
        @(negedge clk);
        bus.sample_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int wr0, nls0;

    initial begin
        bus.sample_i = 1'b0;
        set_ofm_ramp(0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset wr_en", 64'(bus.wr_en_o), 64'd0);
        chk("reset addr", 64'(bus.wr_addr_o), 64'd0);
        chk("reset done", 64'(bus.layer_done_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single pixel, ofm[c]=c
        pulse();
        chk("single first en", 64'(bus.wr_en_o), 64'hF);
        chk("single first addr", 64'(bus.wr_addr_o), 64'd0);
        chk("single first d1", 64'(bus.wr_data_o[1]), 64'd92);
        repeat (91) @(negedge clk);
        chk("single last addr", 64'(bus.wr_addr_o), 64'd5824);
        chk("single last d3", 64'(bus.wr_data_o[3]), 64'd367);
        @(negedge clk);
        chk("single after en", 64'(bus.wr_en_o), 64'd0);
        chk("single hold addr", 64'(bus.wr_addr_o), 64'd5824);
        repeat (3) @(negedge clk);

        // Back-to-back: pixel 1 then pixel 2 chained on its k=91 write
        set_ofm_ramp(1000);
        pulse();
        chk("b2b p1 addr", 64'(bus.wr_addr_o), 64'd1);
        repeat (91) @(negedge clk);
        set_ofm_ramp(2000);
        pulse();
        chk("b2b p2 en", 64'(bus.wr_en_o), 64'hF);
        chk("b2b p2 addr", 64'(bus.wr_addr_o), 64'd2);
        chk("b2b p2 d0", 64'(bus.wr_data_o[0]), 64'd2000);
        chk("b2b overrun", 64'(bus.overrun_o), 64'd0);
        repeat (95) @(negedge clk);

        // Overrun: second sample 10 cycles after the first
        set_ofm_ramp(3000);
        pulse();
        repeat (9) @(negedge clk);
        set_ofm_ramp(7777);
        pulse();
        chk("overrun set", 64'(bus.overrun_o), 64'd1);
        repeat (85) @(negedge clk);
        set_ofm_ramp(4000);
        pulse();
        chk("after overrun addr", 64'(bus.wr_addr_o), 64'd4);
        chk("after overrun d2", 64'(bus.wr_data_o[2]), 64'd4184);

        // Reset at k=40
        repeat (40) @(negedge clk);
        chk("pre-rst addr", 64'(bus.wr_addr_o), 64'(40 * 64 + 4));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst en", 64'(bus.wr_en_o), 64'd0);
        chk("rst overrun", 64'(bus.overrun_o), 64'd0);
        chk("rst addr", 64'(bus.wr_addr_o), 64'd0);
        set_ofm_ramp(500);
        pulse();
        chk("post-rst en", 64'(bus.wr_en_o), 64'hF);
        chk("post-rst addr", 64'(bus.wr_addr_o), 64'd0);
        chk("post-rst d3", 64'(bus.wr_data_o[3]), 64'd776);
        repeat (95) @(negedge clk);

        // Full clean layer, random data, random gaps and chaining
        do_reset();
        wr0 = wr_cnt; nls0 = nls_cnt;
        set_ofm_rand();
        pulse();
        for (int p = 1; p < NPIX; p++) begin
            repeat (91) @(negedge clk);
            if ($urandom_range(0, 1) == 0) repeat (1 + $urandom_range(0, 10)) @(negedge clk);
            set_ofm_rand();
            pulse();
        end
        repeat (95) @(negedge clk);
        chk("layer done", 64'(bus.layer_done_o), 64'd1);
        chk("layer overrun", 64'(bus.overrun_o), 64'd0);
        chk("layer writes", 64'(wr_cnt - wr0), 64'd5888);
        chk("layer nls pulses", 64'(nls_cnt - nls0), 64'd1);

        // Sample after done is ignored
        pulse();
        chk("done en", 64'(bus.wr_en_o), 64'd0);
        chk("done overrun", 64'(bus.overrun_o), 64'd0);
        chk("done sticky", 64'(bus.layer_done_o), 64'd1);
        repeat (3) @(negedge clk);

        // Random sample storm over a whole layer, overruns included
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            bus.sample_i = ($urandom_range(0, 7) == 0);
            if (bus.sample_i) set_ofm_rand();
            @(negedge clk);
        end
        bus.sample_i = 1'b0;
        repeat (100) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fire9_expand1_ofm_writer.md
FIRE9_EXPAND1_OFM_WRITER -- requirements
Module: fire9_expand1_ofm_writer

Interface
REQ-001 SHALL have parameter WIDTH, 16, pixel word width.
REQ-002 SHALL have parameter DSP_NO_FIRE9_EXPAND1, 368, channels per output pixel.
REQ-003 SHALL have parameter WOUT_FIRE9_EXPAND1, 8, output feature-map side; pixels per layer = WOUT_FIRE9_EXPAND1**2 = 64.
REQ-004 SHALL have parameter BANKS, 4, parallel RAM write lanes; DSP_NO_FIRE9_EXPAND1 divisible by BANKS; CPB = DSP_NO_FIRE9_EXPAND1/BANKS = 92.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sample_i  input  1  one-cycle pulse: ofm_i valid this cycle (driven by fire9_expand1_sample).
REQ-008 SHALL have port ofm_i  input  WIDTH x DSP_NO_FIRE9_EXPAND1 (unpacked array)  one output pixel, all channels, ReLU already applied.
REQ-009 SHALL have port wr_en_o  output  BANKS  per-bank RAM write enable.
REQ-010 SHALL have port wr_addr_o  output  clog2(CPB*WOUT**2) = 13  address shared by all banks.
REQ-011 SHALL have port wr_data_o  output  WIDTH x BANKS (unpacked array)  per-bank write data.
REQ-012 SHALL have port layer_done_o  output  1  sticky, all pixels written.
REQ-013 SHALL have port next_layer_start_o  output  1  one-cycle pulse when layer_done_o rises.
REQ-014 SHALL have port overrun_o  output  1  sticky, a sample was dropped.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, DONE; all outputs registered.
REQ-016 IDLE: sample_i=1 SHALL capture ofm_i into a shadow buffer, clear k, go to WRITE.
REQ-017 WRITE: each cycle SHALL assert wr_en_o = all ones, drive bank b data = shadow[b*CPB+k], wr_addr_o = k*WOUT**2 + pix, then increment k.
REQ-018 Latency: sample_i high in cycle t SHALL yield first write (k=0) in cycle t+1 and last write (k=CPB-1) in cycle t+CPB.
REQ-019 At k=CPB-1 SHALL increment pix; if pix was WOUT**2-1, go to DONE, otherwise go to IDLE.
REQ-020 sample_i in the cycle of the k=CPB-1 write, with pix < WOUT**2-1, SHALL be accepted back-to-back: capture, k=0, remain in WRITE, no idle cycle.
REQ-021 sample_i in WRITE with k < CPB-1 SHALL be dropped, set overrun_o, and leave the shadow buffer and counters unchanged.
REQ-022 DONE: layer_done_o SHALL be 1, wr_en_o 0, and sample_i ignored (no overrun); the state SHALL be left only by rst.
REQ-023 next_layer_start_o SHALL be high exactly in the first cycle layer_done_o is 1.
REQ-024 wr_en_o SHALL be 0 in every cycle without a write; wr_addr_o/wr_data_o SHALL hold their last values when idle.
REQ-025 pix SHALL count 0..WOUT**2-1 without wrap; k SHALL count 0..CPB-1.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, k=0, pix=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, layer_done_o=0, next_layer_start_o=0, overrun_o=0.
REQ-027 rst SHALL take priority over sample_i and abort a WRITE mid-pixel; no write SHALL occur in the cycle after the rst edge.
REQ-028 The shadow buffer need not be reset.

Verification
REQ-029 Single pixel: one sample_i, ofm_i[c]=c -> 92 cycles wr_en_o=4'b1111, addr 0,64,...,5824, bank b data = b*92+k, then wr_en_o=0.
REQ-030 Full layer: 64 samples every 113 cycles -> 5888 writes per bank, no overrun, pixel p at addr k*64+p, layer_done_o=1 after the last write, one next_layer_start_o pulse.
REQ-031 Back-to-back: second sample in the cycle of the k=91 write -> next cycle is a k=0 write at addr 1, no gap, overrun_o=0.
REQ-032 Overrun: second sample 10 cycles after the first -> overrun_o=1, first pixel data and addresses undisturbed, pix=1 afterwards.
REQ-033 Reset mid-write: rst at k=40 of pixel 3 -> wr_en_o=0 next cycle, all flags 0; the next sample writes at pix 0.
REQ-034 After done: a further sample_i -> no writes, overrun_o stays 0, layer_done_o stays 1.
